q32_tap_accumulator: RTL and testbench
======================================

# q32_tap_accumulator

Sequential accumulator that consumes the Q32.32 products of the 64x64 signed fixed-point multiplier and sums NTAPS consecutive products into one filter output sample for the anti-noise FIR/LMS path. It sits directly downstream of the multiplier. It holds a guard-banded running sum, saturates the result to 64 bits, and presents it on a valid/ready output handshake with backpressure to the product stream.

## Interface
- NTAPS, 16: products per output sample; legal range 2..1024.
- GUARD, 8: extra integer bits in the internal accumulator; internal width is 64+GUARD.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset. Deassertion is synchronous to clk externally.
- clear  in  1  synchronous frame abort; highest priority.
- prod_in  in  64  signed Q32.32 product from the multiplier.
- prod_valid  in  1  prod_in is valid.
- prod_ready  out  1  block accepts prod_in this cycle.
- sum_out  out  64  signed Q32.32 saturated sum.
- sum_sat  out  1  sum_out was clipped; valid only with sum_valid.
- sum_valid  out  1  sum_out and sum_sat are valid.
- sum_ready  in  1  consumer accepts sum_out.

## Operation
- Accept event: prod_valid && prod_ready.
- Ready rule: prod_ready = !sum_valid || sum_ready. It is combinational and does not depend on prod_valid.
- Registers:
  - acc: signed, 64+GUARD bits.
  - cnt: 0..NTAPS-1.
  - sum_out, sum_sat, sum_valid.
- States:
  - ACC: sum_valid=0, collecting products.
  - HOLD: sum_valid=1, waiting for sum_ready.
- Accept with cnt==0: acc <= sign-extend(prod_in). This discards the previous frame.
- Accept with 0<cnt<NTAPS-1: acc <= acc + sign-extend(prod_in); cnt <= cnt+1.
- Accept with cnt==NTAPS-1 (last tap):
  - Form total = acc + sign-extend(prod_in).
  - sum_out <= sat64(total).
  - sum_sat <= 1 if clipped.
  - sum_valid <= 1; cnt <= 0; state becomes HOLD.
- sat64(x):
  - x > 2^63-1 gives 0x7FFF_FFFF_FFFF_FFFF.
  - x < -2^63 gives 0x8000_0000_0000_0000.
  - Otherwise x[63:0].
- Internal acc never wraps for NTAPS <= 2^GUARD. Wrap for larger NTAPS is undefined and is documented as out of range.
- HOLD exit: sum_valid && sum_ready clears sum_valid at the next edge, unless a new last-tap accept occurs in the same cycle.
- Simultaneous output handoff and product accept is legal. The product starts the next frame at cnt==0 in the same cycle the sum is taken, so the block sustains full throughput.
- sum_out and sum_sat hold their value while sum_valid=1 and sum_ready=0.
- clear=1:
  - Next edge: acc=0, cnt=0, sum_valid=0, sum_sat=0.
  - Any accept in the same cycle is discarded.
  - prod_ready is still driven by the ready rule.

## Timing
- Reset (rst_n low, asynchronous): acc=0, cnt=0, sum_out=0, sum_sat=0, sum_valid=0, state ACC.
- prod_ready is 1 out of reset.
- Latency: sum_valid rises on the clock edge that registers the NTAPS-th accept, so it is visible one cycle after that accept cycle.
- Minimum frame period: NTAPS cycles when prod_valid and sum_ready are held high.
- Backpressure: with sum_valid=1 and sum_ready=0, prod_ready=0 and no product is consumed. The upstream multiplier must hold prod_in and prod_valid.
- Gaps: prod_valid=0 cycles leave acc and cnt unchanged.
- Reset mid-frame aborts the frame immediately, with no partial output.
- Output path: sum_out is registered. prod_ready has a combinational path from sum_ready only.

## Test plan
- Basic sum, NTAPS=4, products 1.0 (0x0000_0001_0000_0000) ×4 with prod_valid continuous and sum_ready=1:
  - sum_out=0x0000_0004_0000_0000, sum_sat=0.
  - sum_valid high for exactly 1 cycle, 1 cycle after the 4th accept.
- Signed mix, NTAPS=4, products +2.5, -1.25, -3.0, +0.5:
  - sum_out=-1.25 = 0xFFFF_FFFE_C000_0000, sum_sat=0.
- Saturation, NTAPS=4, four products of 0x7000_0000_0000_0000:
  - sum_out=0x7FFF_FFFF_FFFF_FFFF, sum_sat=1.
  - The same test with 0x9000_0000_0000_0000 gives 0x8000_0000_0000_0000, sum_sat=1.
- Backpressure, sum_ready=0 for 5 cycles after sum_valid:
  - sum_out stable and prod_ready=0 for those 5 cycles.
  - sum_ready=1 with prod_valid=1 in the same cycle: the sum is handed off and the first product of the next frame is accepted.
  - The next frame result is correct.
- Gaps and clear:
  - Random prod_valid gaps: the result matches the reference model.
  - clear after 2 of 4 products, then 4 products of 1.0: sum_out=4.0.
- Async reset mid-frame: assert rst_n=0 between clock edges.
  - Outputs go to 0 immediately, before the next clk edge.
  - After release, a full frame produces the correct sum with no residue.

Source files
------------

// File: rtl/q32_tap_accumulator_if.sv
// Product-stream / sum-stream handshake bundle for the Q32.32 tap accumulator.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface q32_tap_accumulator_if;
   logic [63:0] prod_in;
   logic        prod_valid;
   logic        prod_ready;
   logic [63:0] sum_out;
   logic        sum_sat;
   logic        sum_valid;
   logic        sum_ready;

   modport slave (
      input  prod_in,
      input  prod_valid,
      output prod_ready,
      output sum_out,
      output sum_sat,
      output sum_valid,
      input  sum_ready
   );

   modport master (
      output prod_in,
      output prod_valid,
      input  prod_ready,
      input  sum_out,
      input  sum_sat,
      input  sum_valid,
      output sum_ready
   );
endinterface

// File: rtl/q32_tap_accumulator.sv
// Sums NTAPS consecutive Q32.32 products in a guard-banded accumulator and
// emits one 64-bit saturated sample per frame on a valid/ready output.
module q32_tap_accumulator #(
   parameter int NTAPS = 16,
   parameter int GUARD = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   q32_tap_accumulator_if.slave    bus
);

   localparam int AW = 64 + GUARD;
   localparam int CW = (NTAPS > 2) ? $clog2(NTAPS) : 1;
   localparam logic [CW-1:0] LAST_TAP = CW'(NTAPS - 1);

   localparam logic [0:0] ST_ACC  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   localparam logic [63:0] SAT_POS = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] SAT_NEG = 64'h8000_0000_0000_0000;

   logic [0:0]    state_q, state_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [63:0]   sum_out_q, sum_out_d;
   logic          sum_sat_q, sum_sat_d;

   logic          prod_ready;
   logic          accept;
   logic          handoff;
   logic [AW-1:0] prod_ext;
   logic [AW:0]   total;
   logic [GUARD+1:0] total_hi;
   logic          in_range;
   logic [63:0]   total_sat;
   logic          total_clipped;

   // Ready only looks at the output side, so a stalled consumer stalls the products.
   assign prod_ready = (state_q == ST_ACC) || bus.sum_ready;
   assign accept     = bus.prod_valid && prod_ready;
   assign handoff    = (state_q == ST_HOLD) && bus.sum_ready;

   assign prod_ext = {{GUARD{bus.prod_in[63]}}, bus.prod_in};
   assign total    = {acc_q[AW-1], acc_q} + {prod_ext[AW-1], prod_ext};

   // Fits in 64 bits exactly when every bit from 63 upward matches the sign.
   assign total_hi      = total[AW:63];
   assign in_range      = (&total_hi) || (~|total_hi);
   assign total_clipped = !in_range;
   assign total_sat     = in_range ? total[63:0] : (total[AW] ? SAT_NEG : SAT_POS);

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      sum_out_d = sum_out_q;
      sum_sat_d = sum_sat_q;

      if (clear) begin
         state_d   = ST_ACC;
         acc_d     = '0;
         cnt_d     = '0;
         sum_sat_d = 1'b0;
      end else begin
         if (handoff) begin
            state_d = ST_ACC;
         end
         if (accept) begin
            if (cnt_q == LAST_TAP) begin
               sum_out_d = total_sat;
               sum_sat_d = total_clipped;
               state_d   = ST_HOLD;
               cnt_d     = '0;
            end else if (cnt_q == '0) begin
               // First tap overwrites whatever the previous frame left behind.
               acc_d = prod_ext;
               cnt_d = cnt_q + 1'b1;
            end else begin
               acc_d = total[AW-1:0];
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_ACC;
         acc_q     <= '0;
         cnt_q     <= '0;
         sum_out_q <= '0;
         sum_sat_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         sum_out_q <= sum_out_d;
         sum_sat_q <= sum_sat_d;
      end
   end

   assign bus.prod_ready = prod_ready;
   assign bus.sum_out    = sum_out_q;
   assign bus.sum_sat    = sum_sat_q;
   assign bus.sum_valid  = (state_q == ST_HOLD);

endmodule

// File: tb/tb_q32_tap_accumulator.sv
// Randomised and directed bench for q32_tap_accumulator against a frame-level model
// (list of accepted products per frame, summed and clipped with wide arithmetic).
module tb_q32_tap_accumulator;

   localparam int NTAPS = 4;
   localparam int GUARD = 8;
   localparam logic signed [127:0] MAXV = 128'sh7FFF_FFFF_FFFF_FFFF;
   localparam logic signed [127:0] MINV = -128'sh8000_0000_0000_0000;
   localparam logic [63:0] ONE = 64'h0000_0001_0000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;

   q32_tap_accumulator_if bus();

   q32_tap_accumulator #(.NTAPS(NTAPS), .GUARD(GUARD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Frame-level reference: products accepted so far, plus the pending output sample.
   logic [63:0] frame_q[$];
   logic        exp_valid = 1'b0;
   logic        exp_sat = 1'b0;
   logic [63:0] exp_out = '0;
   logic        last_accept = 1'b0;
   bit          run_checks = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      frame_q.delete();
      exp_valid = 1'b0;
      exp_sat = 1'b0;
      exp_out = '0;
   endfunction

   function automatic void model_close_frame();
      logic signed [127:0] tot;
      tot = '0;
      foreach (frame_q[i]) tot = tot + $signed({{64{frame_q[i][63]}}, frame_q[i]});
      if (tot > MAXV) begin
         exp_out = 64'h7FFF_FFFF_FFFF_FFFF;
         exp_sat = 1'b1;
      end else if (tot < MINV) begin
         exp_out = 64'h8000_0000_0000_0000;
         exp_sat = 1'b1;
      end else begin
         exp_out = tot[63:0];
         exp_sat = 1'b0;
      end
      exp_valid = 1'b1;
      frame_q.delete();
   endfunction

   // Called at the active edge with the inputs that were presented for that cycle.
   function automatic void model_step();
      logic ready;
      logic handoff;
      ready = !exp_valid || bus.sum_ready;
      handoff = exp_valid && bus.sum_ready;
      last_accept = 1'b0;
      if (clear) begin
         frame_q.delete();
         exp_valid = 1'b0;
         exp_sat = 1'b0;
      end else begin
         if (handoff) exp_valid = 1'b0;
         if (bus.prod_valid && ready) begin
            last_accept = 1'b1;
            frame_q.push_back(bus.prod_in);
            if (frame_q.size() == NTAPS) model_close_frame();
         end
      end
   endfunction

   // Compare process: mid-cycle, every cycle out of reset.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && run_checks) begin
            chk("prod_ready", 64'(bus.prod_ready), 64'(!exp_valid || bus.sum_ready));
            chk("sum_valid", 64'(bus.sum_valid), 64'(exp_valid));
            if (exp_valid) begin
               chk("sum_out", bus.sum_out, exp_out);
               chk("sum_sat", 64'(bus.sum_sat), 64'(exp_sat));
            end
         end
      end
   end

   task automatic drive(input logic pv, input logic [63:0] pd, input logic sr, input logic clr);
      bus.prod_valid = pv;
      bus.prod_in = pd;
      bus.sum_ready = sr;
      clear = clr;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic frame(input logic [63:0] p0, input logic [63:0] p1,
                        input logic [63:0] p2, input logic [63:0] p3, input logic sr);
      drive(1'b1, p0, sr, 1'b0);
      drive(1'b1, p1, sr, 1'b0);
      drive(1'b1, p2, sr, 1'b0);
      drive(1'b1, p3, sr, 1'b0);
   endtask

   task automatic lit(input string name, input logic [63:0] sum, input logic sat);
      chk({name, "_valid"}, 64'(bus.sum_valid), 64'd1);
      chk({name, "_sum"}, bus.sum_out, sum);
      chk({name, "_sat"}, 64'(bus.sum_sat), 64'(sat));
      chk({name, "_model"}, exp_out, sum);
   endtask

   task automatic async_reset();
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_sum_valid", 64'(bus.sum_valid), 64'd0);
      chk("rst_sum_out", bus.sum_out, 64'd0);
      chk("rst_sum_sat", 64'(bus.sum_sat), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic        pv;
      logic        sr;
      logic        clr;
      logic        hold;
      logic [63:0] pd;

      bus.prod_valid = 1'b0;
      bus.prod_in = '0;
      bus.sum_ready = 1'b0;
      clear = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_sum_valid", 64'(bus.sum_valid), 64'd0);
      chk("reset_sum_out", bus.sum_out, 64'd0);
      chk("reset_sum_sat", 64'(bus.sum_sat), 64'd0);
      chk("reset_prod_ready", 64'(bus.prod_ready), 64'd1);
      rst_n = 1'b1;
      run_checks = 1'b1;

      // Basic 4 x 1.0, sum_valid for exactly one cycle (checked by the compare process).
      frame(ONE, ONE, ONE, ONE, 1'b1);
      lit("basic", 64'h0000_0004_0000_0000, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0);
      chk("basic_pulse", 64'(bus.sum_valid), 64'd0);

      frame(64'h0000_0002_8000_0000, 64'hFFFF_FFFE_C000_0000,
            64'hFFFF_FFFD_0000_0000, 64'h0000_0000_8000_0000, 1'b1);
      lit("signed", 64'hFFFF_FFFE_C000_0000, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0);

      frame(64'h7000_0000_0000_0000, 64'h7000_0000_0000_0000,
            64'h7000_0000_0000_0000, 64'h7000_0000_0000_0000, 1'b1);
      lit("sat_pos", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
      drive(1'b0, '0, 1'b1, 1'b0);

      frame(64'h9000_0000_0000_0000, 64'h9000_0000_0000_0000,
            64'h9000_0000_0000_0000, 64'h9000_0000_0000_0000, 1'b1);
      lit("sat_neg", 64'h8000_0000_0000_0000, 1'b1);
      drive(1'b0, '0, 1'b1, 1'b0);

      // Backpressure: hold 5 cycles, then handoff with simultaneous accept.
      frame(ONE, ONE, ONE, ONE, 1'b0);
      lit("bp_hold", 64'h0000_0004_0000_0000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 64'h0000_0002_0000_0000, 1'b0, 1'b0);
         chk("bp_stable", bus.sum_out, 64'h0000_0004_0000_0000);
      end
      drive(1'b1, 64'h0000_0002_0000_0000, 1'b1, 1'b0);
      chk("bp_first_accept", 64'(last_accept), 64'd1);
      for (int i = 0; i < 3; i++) drive(1'b1, 64'h0000_0002_0000_0000, 1'b1, 1'b0);
      lit("bp_next", 64'h0000_0008_0000_0000, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0);

      // Clear after 2 of 4 products; the product offered with clear is dropped.
      drive(1'b1, ONE, 1'b1, 1'b0);
      drive(1'b1, ONE, 1'b1, 1'b0);
      drive(1'b1, ONE, 1'b1, 1'b1);
      frame(ONE, ONE, ONE, ONE, 1'b1);
      lit("clear", 64'h0000_0004_0000_0000, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0);

      // Async reset while holding a sample, then mid-frame, then a clean frame.
      frame(64'h0000_0003_0000_0000, 64'h0000_0003_0000_0000,
            64'h0000_0003_0000_0000, 64'h0000_0003_0000_0000, 1'b0);
      lit("pre_reset", 64'h0000_000C_0000_0000, 1'b0);
      async_reset();
      drive(1'b1, 64'h0000_0005_0000_0000, 1'b1, 1'b0);
      drive(1'b1, 64'h0000_0005_0000_0000, 1'b1, 1'b0);
      async_reset();
      frame(ONE, ONE, ONE, ONE, 1'b1);
      lit("post_reset", 64'h0000_0004_0000_0000, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0);

      // Random traffic; a stalled product is held until it is taken.
      hold = 1'b0;
      pv = 1'b0;
      pd = '0;
      for (int n = 0; n < 3000; n++) begin
         if (!hold) begin
            pv = ($urandom_range(0, 9) < 7);
            pd = {$urandom, $urandom};
            case ($urandom_range(0, 3))
               0: pd = {{16{pd[47]}}, pd[47:0]};
               1: pd = {{32{pd[35]}}, pd[35:4], 4'h0};
               default: ;
            endcase
         end
         sr = ($urandom_range(0, 9) < 7);
         clr = ($urandom_range(0, 99) < 2);
         drive(pv, pd, sr, clr);
         hold = pv && !last_accept && !clr;
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0);

      run_checks = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
